// File: rtl/wavetable_pkg.sv
// Shared parameters, FSM encoding and helpers for the eight-voice wavetable reader.
package wavetable_pkg;

  localparam int unsigned NUM_VOICES     = 8;
  localparam int unsigned NUM_TABLES     = 10;
  localparam int unsigned TABLE_LEN_LOG2 = 6;
  localparam int unsigned ROM_ADDR_W     = 10;
  localparam int unsigned ACC_W          = 24;
  localparam int unsigned VOICE_W        = $clog2(NUM_VOICES);
  localparam int unsigned TABLE_W        = 4;
  localparam int unsigned INC_W          = 16;
  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned FRAC_W         = 8;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    LAT  = 2'd3
  } state_e;

  typedef struct packed {
    logic               en;
    logic [TABLE_W-1:0] tbl;
    logic [INC_W-1:0]   inc;
  } voice_cfg_t;

  // Out-of-range table selects alias onto table 0.
  function automatic logic [TABLE_W-1:0] clamp_table(input logic [TABLE_W-1:0] t);
    return (32'(t) < NUM_TABLES) ? t : '0;
  endfunction

  function automatic logic [ROM_ADDR_W-1:0] table_addr(input logic [TABLE_W-1:0]        tbl,
                                                       input logic [TABLE_LEN_LOG2-1:0] idx);
    return ROM_ADDR_W'({tbl, idx});
  endfunction

endpackage

// File: rtl/wavetable_interp.sv
// Linear interpolation between two adjacent unsigned table entries.
module wavetable_interp
  import wavetable_pkg::*;
(
  input  logic [SAMPLE_W-1:0] s0,
  input  logic [SAMPLE_W-1:0] s1,
  input  logic [FRAC_W-1:0]   frac,
  output logic [SAMPLE_W-1:0] sample_c
);

  localparam int unsigned PROD_W = SAMPLE_W + FRAC_W + 1;

  logic signed [SAMPLE_W:0] diff_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [SAMPLE_W:0] delta_c;

  // Floor division by 256 via arithmetic shift keeps the result inside [min(s0,s1), max(s0,s1)].
  always_comb begin
    diff_c   = $signed({1'b0, s1}) - $signed({1'b0, s0});
    prod_c   = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac}));
    delta_c  = (SAMPLE_W + 1)'(prod_c >>> FRAC_W);
    sample_c = SAMPLE_W'($signed({1'b0, s0}) + delta_c);
  end

endmodule

// File: rtl/wavetable_voice_reader.sv
// Eight-voice wavetable reader: per tick, fetches two ROM entries per voice and emits one interpolated sample each.
module wavetable_voice_reader
  import wavetable_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  cfg_we,
  input  logic [VOICE_W-1:0]    cfg_voice,
  input  logic                  cfg_en,
  input  logic [TABLE_W-1:0]    cfg_table,
  input  logic [INC_W-1:0]      cfg_inc,
  output logic                  rom_re,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [SAMPLE_W-1:0]   rom_data,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic [VOICE_W-1:0]    sample_voice,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  state_e                    state_q, state_d;
  logic [VOICE_W-1:0]        voice_q, voice_d;
  voice_cfg_t                cfg_q [NUM_VOICES];
  voice_cfg_t                cfg_d [NUM_VOICES];
  logic [ACC_W-1:0]          acc_q [NUM_VOICES];
  logic [ACC_W-1:0]          acc_d [NUM_VOICES];
  logic [SAMPLE_W-1:0]       s0_q, s0_d;
  logic [SAMPLE_W-1:0]       sample_out_q, sample_out_d;
  logic [VOICE_W-1:0]        sample_voice_q, sample_voice_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;
  logic                      rom_re_q, rom_re_d;
  logic [ROM_ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [FRAC_W-1:0]         frac_c;
  logic [SAMPLE_W-1:0]       interp_c;
  logic [TABLE_LEN_LOG2-1:0] rd_idx_c;

  assign frac_c = acc_q[voice_q][ACC_W-TABLE_LEN_LOG2-1 -: FRAC_W];

  wavetable_interp u_interp (
    .s0       (s0_q),
    .s1       (rom_data),
    .frac     (frac_c),
    .sample_c (interp_c)
  );

  always_comb begin
    state_d        = state_q;
    voice_d        = voice_q;
    cfg_d          = cfg_q;
    acc_d          = acc_q;
    s0_d           = s0_q;
    sample_out_d   = sample_out_q;
    sample_voice_d = sample_voice_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q;
    rom_re_d       = 1'b0;
    rom_addr_d     = '0;
    rd_idx_c       = '0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = RD0;
          voice_d = '0;
        end
      end
      RD0: state_d = RD1;
      RD1: begin
        state_d = LAT;
        s0_d    = rom_data;
      end
      LAT: begin
        sample_valid_d = 1'b1;
        sample_voice_d = voice_q;
        if (cfg_q[voice_q].en) begin
          sample_out_d   = interp_c;
          acc_d[voice_q] = acc_q[voice_q] + ACC_W'(cfg_q[voice_q].inc);
        end else begin
          sample_out_d = SAMPLE_MID;
        end
        if (voice_q == VOICE_W'(NUM_VOICES - 1)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = RD0;
          voice_d = VOICE_W'(voice_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // A config write overrides the LAT phase update of the same voice.
    if (cfg_we) begin
      cfg_d[cfg_voice] = '{en: cfg_en, tbl: clamp_table(cfg_table), inc: cfg_inc};
      acc_d[cfg_voice] = '0;
    end

    // ROM request is registered, so it is derived from the state being entered.
    rd_idx_c = acc_d[voice_d][ACC_W-1 -: TABLE_LEN_LOG2];
    if (cfg_d[voice_d].en && ((state_d == RD0) || (state_d == RD1))) begin
      rom_re_d   = 1'b1;
      rom_addr_d = table_addr(cfg_d[voice_d].tbl,
                              (state_d == RD1) ? TABLE_LEN_LOG2'(rd_idx_c + 1'b1) : rd_idx_c);
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      voice_q        <= '0;
      cfg_q          <= '{default: '0};
      acc_q          <= '{default: '0};
      s0_q           <= '0;
      sample_out_q   <= SAMPLE_MID;
      sample_voice_q <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      rom_re_q       <= 1'b0;
      rom_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      voice_q        <= voice_d;
      cfg_q          <= cfg_d;
      acc_q          <= acc_d;
      s0_q           <= s0_d;
      sample_out_q   <= sample_out_d;
      sample_voice_q <= sample_voice_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
      rom_re_q       <= rom_re_d;
      rom_addr_q     <= rom_addr_d;
    end
  end

  assign rom_re       = rom_re_q;
  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_voice = sample_voice_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_reader.sv
// Scoreboard bench for wavetable_voice_reader: a reference voice model predicts ROM reads and samples per frame.
module tb_wavetable_voice_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       cfg_we;
  logic [2:0] cfg_voice;
  logic       cfg_en;
  logic [3:0] cfg_table;
  logic [15:0] cfg_inc;
  logic       rom_re;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] sample_out;
  logic [2:0] sample_voice;
  logic       sample_valid;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  wavetable_voice_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_en       (cfg_en),
    .cfg_table    (cfg_table),
    .cfg_inc      (cfg_inc),
    .rom_re       (rom_re),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_voice (sample_voice),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] voice; logic [7:0] val; int cyc; } exp_t;
  typedef struct { logic [9:0] addr; int cyc; } rd_t;

  logic [7:0]  rom [1024];
  exp_t        exp_q[$];
  rd_t         rd_q[$];
  logic [7:0]  last_sample [8];
  int          m_en [8];
  int          m_tbl [8];
  int unsigned m_inc [8];
  int unsigned m_acc [8];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          tick_cyc = 0;
  int          bad192 = 0;
  int          seen_wrap = 0;
  int          prev_addr = -1;
  logic        exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rom_re) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] ref_interp(input int s0, input int s1, input int frac);
    int p;
    p = (s1 - s0) * frac;
    return 8'(s0 + (p >>> 8));
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 8; v++) begin
      m_en[v] = 0; m_tbl[v] = 0; m_inc[v] = 0; m_acc[v] = 0;
    end
  endtask

  task automatic write_cfg(input int v, input int en, input int tbl, input int unsigned inc);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_voice = 3'(v); cfg_en = 1'(en); cfg_table = 4'(tbl); cfg_inc = 16'(inc);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_en[v] = en; m_tbl[v] = (tbl > 9) ? 0 : tbl; m_inc[v] = inc & 32'hFFFF; m_acc[v] = 0;
  endtask

  task automatic push_frame(input int t0);
    for (int v = 0; v < 8; v++) begin
      int c0, idx, fr, a0, a1;
      logic [7:0] val;
      c0 = t0 + 1 + 3 * v;
      if (m_en[v] != 0) begin
        idx = int'((m_acc[v] >> 18) & 63);
        fr  = int'((m_acc[v] >> 10) & 255);
        a0  = m_tbl[v] * 64 + idx;
        a1  = m_tbl[v] * 64 + ((idx + 1) % 64);
        rd_q.push_back('{addr: 10'(a0), cyc: c0});
        rd_q.push_back('{addr: 10'(a1), cyc: c0 + 1});
        val = ref_interp(int'(rom[a0]), int'(rom[a1]), fr);
        m_acc[v] = (m_acc[v] + m_inc[v]) & 32'h00FF_FFFF;
      end else begin
        val = 8'h80;
      end
      exp_q.push_back('{voice: 3'(v), val: val, cyc: c0 + 3});
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_rom_re", rom_re, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_sample_out", sample_out, 8'h80);
    chk("rst_sample_voice", sample_voice, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // Called in the cycle the tick should be driven; returns at the negedge of cycle 25.
  task automatic run_frame(input int ovr_at, input int rst_at);
    tick = 1'b1;
    tick_cyc = cyc;
    push_frame(tick_cyc);
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        rd_q.delete();
        model_reset();
        exp_ovr = 1'b0;
        #1;
        check_reset_outputs();
        break;
      end
      chk("busy", busy, 32'(k <= 24));
      chk("frame_done", frame_done, 32'(k == 25));
      if (k == ovr_at) exp_ovr = 1'b1;
      tick = (k == ovr_at);
    end
    if (rst_at == 0) chk("overrun", overrun, exp_ovr);
  endtask

  // Monitor: every ROM read and every sample is matched against the scoreboard.
  always @(negedge clk) begin
    rd_t  r;
    exp_t e;
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      chk("rd_missing", cyc, rd_q[0].cyc);
      void'(rd_q.pop_front());
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("sample_missing", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (rom_re) begin
      if (rom_addr == 10'd192) bad192++;
      if (prev_addr == 191 && rom_addr == 10'd128) seen_wrap = 1;
      prev_addr = int'(rom_addr);
      if (rd_q.size() == 0) begin
        chk("rd_pending", 32'(rd_q.size()), 1);
      end else begin
        r = rd_q.pop_front();
        chk("rd_addr", rom_addr, r.addr);
        chk("rd_cyc", cyc, r.cyc);
      end
    end else begin
      prev_addr = -1;
      chk("addr_idle", rom_addr, 0);
    end
    if (sample_valid) begin
      last_sample[sample_voice] = sample_out;
      if (exp_q.size() == 0) begin
        chk("sample_pending", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sample_voice", sample_voice, e.voice);
        chk("sample_out", sample_out, e.val);
        chk("sample_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_en = 1'b0; cfg_table = '0; cfg_inc = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h10; rom[1] = 8'h30; rom[64] = 8'hF0; rom[65] = 8'h10;
    for (int v = 0; v < 8; v++) last_sample[v] = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Voice 0 ramps to frac 0x80 at index 0; voice 2 walks table 2 up to index 63.
    write_cfg(0, 1, 0, 16'h0200);
    write_cfg(2, 1, 2, 16'hFFFF);
    for (int n = 0; n < 257; n++) begin
      @(posedge clk); #1;
      run_frame(0, 0);
    end
    chk("interp_up_0x20", last_sample[0], 8'h20);
    chk("no_addr_192", bad192, 0);
    chk("wrap_191_to_128", seen_wrap, 1);

    // Falling edge interpolation: 0xF0 -> 0x10 at frac 0x40.
    write_cfg(1, 1, 1, 16'h8000);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      run_frame(0, 0);
    end
    chk("interp_down_0xB8", last_sample[1], 8'hB8);

    // All voices active, including out-of-range table selects; second tick lands on cycle 25.
    write_cfg(3, 1, 5, $urandom_range(0, 65535));
    write_cfg(4, 1, 12, $urandom_range(0, 65535));
    write_cfg(5, 1, 9, $urandom_range(0, 65535));
    write_cfg(6, 1, 15, $urandom_range(0, 65535));
    write_cfg(7, 1, 7, $urandom_range(0, 65535));
    @(posedge clk); #1;
    run_frame(0, 0);
    run_frame(0, 0);

    // Voice 3 muted and a tick arrives mid-frame.
    write_cfg(3, 0, 5, 16'h0000);
    @(posedge clk); #1;
    run_frame(10, 0);
    chk("muted_voice3", last_sample[3], 8'h80);

    // Reset in the middle of a frame, then restart from voice 0.
    @(posedge clk); #1;
    run_frame(0, 8);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    write_cfg(0, 1, 3, 16'h1234);
    write_cfg(6, 1, 4, 16'h4321);
    @(posedge clk); #1;
    run_frame(0, 0);
    @(posedge clk); #1;
    run_frame(0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size() + rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wavetable_voice_reader.md
WAVETABLE_VOICE_READER -- requirements
Module: wavetable_voice_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on posedge clk.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port tick, input, 1 bit: sample-rate strobe that starts one frame.
REQ-004 SHALL have port cfg_we, input, 1 bit: voice configuration write strobe.
REQ-005 SHALL have port cfg_voice, input, 3 bits: target voice, 0..7.
REQ-006 SHALL have port cfg_en, input, 1 bit: voice enable.
REQ-007 SHALL have port cfg_table, input, 4 bits: table select; 0..9 valid, 10..15 treated as 0.
REQ-008 SHALL have port cfg_inc, input, 16 bits: phase increment.
REQ-009 SHALL have port rom_re, output, 1 bit: ROM read enable.
REQ-010 SHALL have port rom_addr, output, 10 bits: ROM address.
REQ-011 SHALL have port rom_data, input, 8 bits: ROM data, valid the cycle after rom_re.
REQ-012 SHALL have port sample_out, output, 8 bits: interpolated unsigned sample.
REQ-013 SHALL have port sample_voice, output, 3 bits: voice that produced sample_out.
REQ-014 SHALL have port sample_valid, output, 1 bit: one-cycle qualifier for sample_out.
REQ-015 SHALL have port busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse after voice 7 output.
REQ-017 SHALL have port overrun, output, 1 bit: sticky; set when tick arrives while busy.

Function
REQ-018 SHALL keep, per voice, a 24-bit phase accumulator acc plus registered en, table and inc; index = acc[23:18], frac = acc[17:10].
REQ-019 SHALL treat each table as 64 entries with addr = table*64 + index.
REQ-020 SHALL use FSM states IDLE, RD0, RD1, LAT and process voices 0..7 in order, three cycles per voice.
REQ-021 SHALL move IDLE->RD0 (voice 0) on tick, RD0->RD1->LAT, then LAT->RD0 of the next voice, or LAT->IDLE after voice 7.
REQ-022 SHALL, in RD0, assert rom_re with addr(index); in RD1, assert rom_re with addr((index+1) mod 64) and latch rom_data as s0.
REQ-023 SHALL wrap addr((index+1) mod 64) within the same table, so index 63 reads entry 0 of that table and never crosses into the next table.
REQ-024 SHALL, in LAT, take s1 = rom_data and register sample_out = s0 + ((s1 - s0) * frac) >>> 8, using a 9-bit signed difference and a 17-bit signed product; the result is always within 0..255.
REQ-025 SHALL, in LAT, update acc = (acc + zero-extended inc) mod 2^24 for enabled voices.
REQ-026 SHALL, for a disabled voice, keep rom_re low, output 8'h80, leave acc unchanged and still spend three cycles.
REQ-027 SHALL, with tick at cycle 0, pulse sample_valid for voice v at cycle 4+3v and pulse frame_done at cycle 25; busy is high in cycles 1..24.
REQ-028 SHALL accept a tick at cycle 25; a tick while busy is ignored and sets overrun.
REQ-029 SHALL apply cfg_we on the next posedge, clearing acc of that voice to 0; a write during a frame is used from the next state onward.
REQ-030 SHALL hold rom_re low in IDLE, and drive rom_addr to 0 whenever rom_re is low.

Reset
REQ-031 SHALL, with rst_n low, drive state IDLE; rom_re, sample_valid, busy, frame_done and overrun 0; rom_addr 0; sample_out 8'h80; sample_voice 0; all acc, en, table and inc 0.
REQ-032 SHALL, on reset mid-frame, abort the frame immediately with no further ROM reads or outputs.

Structure
REQ-033 SHALL take NUM_VOICES=8, NUM_TABLES=10, TABLE_LEN_LOG2=6, ROM_ADDR_W=10, ACC_W=24 and the FSM state encoding from the shared package wavetable_pkg.
REQ-034 SHALL place the interpolation arithmetic in a combinational sub-module wavetable_interp.

Verification
REQ-035 SHALL cover this scenario: ROM entries 0x10 at 0 and 0x30 at 1, voice 0 with inc=0x0200, and acc preset so frac=0x80 -> sample_out 0x20.
REQ-036 SHALL cover this scenario: s0=0xF0, s1=0x10, frac=0x40 -> sample_out 0xB8.
REQ-037 SHALL cover this scenario: table 2 at index 63 -> reads at addresses 191 then 128, never 192.
REQ-038 SHALL cover this scenario: all voices enabled and a tick at cycle 0 -> sample_valid at cycles 4,7,...,25 with voices 0..7, and frame_done at 25.
REQ-039 SHALL cover this scenario: a tick at cycle 10 of a frame -> ignored and overrun=1; voice 3 disabled -> 0x80 with no rom_re during its slot.
REQ-040 SHALL cover this scenario: rst_n low at cycle 8 -> all outputs at their reset values, and the next tick starts again from voice 0.
